morph_window_sched: RTL and testbench
=====================================

// Module: morph_window_sched
// PURPOSE
// - Sequences a line-buffer column window for the erosion/dilation HLS kernels (ap_ctrl_hs).
// - Sits between the pixel stream and NROWS-1 dual-port row-buffer BRAMs plus one HLS kernel instance.
// - Reads and writes back the row cascade, assembles an NROWS-tall column per pixel and issues ap_start/init.
// - Raises a pixel-valid pulse per kernel result and flags dropped columns.
// PARAMETERS
// - IMG_W   640  pixels per row; IMG_W >= 4; col counter is ADDR_W bits
// - NROWS   19   window height; kernel inputs in0..in(NROWS-1)
// - DW      8    pixel width
// - ADDR_W  10   row-buffer address width; 2**ADDR_W >= IMG_W
// PORTS
// - s_axi_aclk      in   1              single clock, all logic rising edge
// - s_axi_areset    in   1              synchronous, active-high reset
// - sensor_state    in   1              frame active; rise = frame start, fall = frame end
// - pix_valid       in   1              input pixel strobe, no backpressure
// - pix_din         in   DW             input pixel
// - rowbuf_rden     out  1              read enable, shared by all buffers
// - rowbuf_rdaddr   out  ADDR_W         read address (= current column)
// - rowbuf_rddata   in   (NROWS-1)*DW   buffer j data at [j*DW +: DW], 1-cycle latency
// - rowbuf_wren     out  1              write enable, shared
// - rowbuf_wraddr   out  ADDR_W         write address
// - rowbuf_wrdata   out  (NROWS-1)*DW   buffer j write data
// - win_col         out  NROWS*DW       kernel column; in_k = win_col[k*DW +: DW]
// - ap_start        out  1              HLS start; held until ap_ready
// - ap_ready        in   1              HLS accepted inputs
// - ap_done         in   1              HLS result valid
// - init            out  1              column 0 of a row; qualified by ap_start
// - out_valid       out  1              1-cycle pulse, registered copy of ap_done
// - ovf             out  1              sticky: column dropped; cleared at frame start or reset
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; col=0; row=0; pending slot empty.
// - FSM states: IDLE, RUN, DRAIN.
//   - IDLE->RUN on sensor_state rise: col=0, row=0, ovf=0.
//   - RUN->DRAIN on sensor_state fall.
//   - DRAIN->IDLE when slot empty and ap_start is low.
//   - In IDLE, pix_valid is ignored.
// - Stage S0 (pix_valid in RUN): rden=1, rdaddr=col; latch pixel and col.
//   - The pixel presented in the same cycle as the sensor_state fall is still accepted.
// - Stage S1, one cycle later: col_vec[0]=pixel, col_vec[k]=rddata[k-1] for k=1..NROWS-1.
//   - Write col_vec[j] into buffer j at the same column (wren=1), j=0..NROWS-2.
//   - Buffer j therefore holds row y-j-1.
// - Column counter: increments per accepted pixel; IMG_W-1 wraps to 0 and increments row.
//   - row saturates at NROWS-1.
// - Handshake, 1-deep slot:
//   - The S1 column loads the slot when the slot is empty, or frees in the same cycle via ap_ready.
//   - win_col and init are driven from the slot.
//   - ap_start=1 while the slot is full; the slot clears on ap_start&&ap_ready.
//   - If the slot is still full at S1: ovf<=1 and the column is not sent.
//   - The BRAM write-back still occurs, so the row cascade stays consistent.
// - Latency: pix_valid to ap_start = 2 cycles with the slot free; ap_done to out_valid = 1 cycle.
// - Mid-frame reset: the slot is dropped, ap_start drops immediately, and the FSM returns to IDLE.
//   - The kernel shares the reset, so no partial op survives.
// CONFIGURATION
// - MORPH_BORDER_FILL_EN defined:
//   - col_vec[k] is forced to 0 for k > row during the first NROWS-1 rows (stale BRAM masked).
//   - 0 is the neutral value for dilation/max.
// - MORPH_BORDER_FILL_EN undefined: raw rddata is passed through; the row counter is still kept.
// STRUCTURE
// - morph_pkg holds:
//   - default constants IMG_W, NROWS, DW, ADDR_W
//   - state enum {IDLE, RUN, DRAIN}
//   - column-vector width helper
// - One sub-module, morph_hs_slot: the 1-deep ap_ctrl_hs holding register (load/ready/ovf logic).
// TESTING
// - Reset then frame start, 1 pixel 0x5A at col 0:
//   - rden@t+0, addr 0; wren@t+1, wrdata[0]=0x5A
//   - ap_start@t+2 with init=1
//   - win_col[0]=0x5A
// - Feed IMG_W*3 ramp pixels, ap_ready tied 1:
//   - after the wrap, rdaddr returns 0 and row=1
//   - on row 2, win_col[1] = row-1 value and win_col[2] = row-0 value at the same column
// - Hold ap_ready=0 for 3 pixels:
//   - ap_start stays high with the first column
//   - ovf=1
//   - wren still pulses 3 times
// - With MORPH_BORDER_FILL_EN and BRAM preloaded 0xFF, on row 0:
//   - win_col[1..18]=0
//   - the undefined build shows 0xFF
// - sensor_state falls with the slot full:
//   - state DRAIN until ap_ready, then IDLE
//   - later pix_valid yields no rden
// - Reset asserted while ap_start=1: next cycle ap_start=0, ovf=0, state IDLE.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared constants, FSM state type and width helper for the morphology window scheduler.
package morph_pkg;

    localparam int unsigned IMG_W  = 640;
    localparam int unsigned NROWS  = 19;
    localparam int unsigned DW     = 8;
    localparam int unsigned ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of one assembled kernel column (NROWS pixels of DW bits).
    function automatic int unsigned col_vec_w(input int unsigned nrows, input int unsigned dw);
        return nrows * dw;
    endfunction

endpackage

// File: rtl/morph_hs_slot.sv
// One-deep ap_ctrl_hs holding register: keeps a column until the kernel accepts it,
// and flags columns that arrive while it is still occupied.
module morph_hs_slot
    import morph_pkg::*;
#(
    parameter int unsigned COL_W = morph_pkg::col_vec_w(morph_pkg::NROWS, morph_pkg::DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             col_valid,
    input  logic [COL_W-1:0] col_data,
    input  logic             col_init,
    input  logic             ovf_clr,
    input  logic             ap_ready,
    output logic             ap_start,
    output logic [COL_W-1:0] win_col,
    output logic             init,
    output logic             ovf
);

    // A column may enter when the slot is empty or is being emptied this cycle.
    logic load;
    assign load = col_valid && (!ap_start || ap_ready);

    // Slot occupancy, payload and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ap_start <= 1'b0;
            win_col  <= '0;
            init     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (load) begin
                ap_start <= 1'b1;
                win_col  <= col_data;
                init     <= col_init;
            end else if (ap_start && ap_ready) begin
                ap_start <= 1'b0;
            end

            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (col_valid && ap_start && !ap_ready) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/morph_window_sched.sv
// Line-buffer column window sequencer for the erosion/dilation HLS kernels.
// Optional feature: define MORPH_BORDER_FILL_EN to zero stale row-buffer lanes
// during the first NROWS-1 rows of a frame.
module morph_window_sched
    import morph_pkg::*;
#(
    parameter int unsigned IMG_W  = morph_pkg::IMG_W,
    parameter int unsigned NROWS  = morph_pkg::NROWS,
    parameter int unsigned DW     = morph_pkg::DW,
    parameter int unsigned ADDR_W = morph_pkg::ADDR_W
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  sensor_state,
    input  logic                  pix_valid,
    input  logic [DW-1:0]         pix_din,
    output logic                  rowbuf_rden,
    output logic [ADDR_W-1:0]     rowbuf_rdaddr,
    input  logic [(NROWS-1)*DW-1:0] rowbuf_rddata,
    output logic                  rowbuf_wren,
    output logic [ADDR_W-1:0]     rowbuf_wraddr,
    output logic [(NROWS-1)*DW-1:0] rowbuf_wrdata,
    output logic [NROWS*DW-1:0]   win_col,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic                  init,
    output logic                  out_valid,
    output logic                  ovf
);

    localparam int unsigned COL_W = col_vec_w(NROWS, DW);
    localparam int unsigned BUF_W = (NROWS - 1) * DW;
    localparam int unsigned ROW_W = $clog2(NROWS);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NROWS - 1);

    state_t            state;
    logic              sens_q;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic              s1_valid;
    logic [DW-1:0]     s1_pix;
    logic [ADDR_W-1:0] s1_col;
`ifdef MORPH_BORDER_FILL_EN
    logic [ROW_W-1:0]  s1_row;
`endif
    logic [COL_W-1:0]  col_vec;
    logic              accept;
    logic              frame_start;
    logic              frame_end;

    assign frame_start = sensor_state && !sens_q;
    assign frame_end   = !sensor_state && sens_q;
    // A pixel on the falling-edge cycle is still taken because state is RUN then.
    assign accept      = (state == RUN) && pix_valid;

    // FSM, column/row counters and S0 -> S1 pipeline register.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state    <= IDLE;
            sens_q   <= 1'b0;
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
`ifdef MORPH_BORDER_FILL_EN
            s1_row   <= '0;
`endif
        end else begin
            sens_q   <= sensor_state;
            s1_valid <= accept;
            if (accept) begin
                s1_pix <= pix_din;
                s1_col <= col;
`ifdef MORPH_BORDER_FILL_EN
                s1_row <= row;
`endif
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row != ROW_LAST) begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + ADDR_W'(1);
                        end
                    end
                    if (frame_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait for the last in-flight column to be handed to the kernel.
                    if (!s1_valid && !ap_start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S1 column assembly: fresh pixel on top of the row cascade read back from the buffers.
    always_comb begin
        col_vec = '0;
        col_vec[0 +: DW] = s1_pix;
        for (int k = 1; k < NROWS; k++) begin
`ifdef MORPH_BORDER_FILL_EN
            if (ROW_W'(k) <= s1_row) begin
                col_vec[k*DW +: DW] = rowbuf_rddata[(k-1)*DW +: DW];
            end
`else
            col_vec[k*DW +: DW] = rowbuf_rddata[(k-1)*DW +: DW];
`endif
        end
    end

    assign rowbuf_rden   = accept;
    assign rowbuf_rdaddr = col;
    assign rowbuf_wren   = s1_valid;
    assign rowbuf_wraddr = s1_col;
    assign rowbuf_wrdata = s1_valid ? col_vec[BUF_W-1:0] : '0;

    // Result strobe towards the pixel sink.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= ap_done;
        end
    end

    morph_hs_slot #(
        .COL_W (COL_W)
    ) u_slot (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .col_valid (s1_valid),
        .col_data  (col_vec),
        .col_init  (s1_col == '0),
        .ovf_clr   ((state == IDLE) && frame_start),
        .ap_ready  (ap_ready),
        .ap_start  (ap_start),
        .win_col   (win_col),
        .init      (init),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_morph_window_sched.sv
// Self-checking bench for morph_window_sched: directed cycle table, random frame
// against an image-level reference, and a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_morph_window_sched;
    import morph_pkg::*;

    localparam int unsigned NB = NROWS - 1;
    localparam int unsigned CW = NROWS * DW;
`ifdef MORPH_BORDER_FILL_EN
    localparam logic [DW-1:0] STALE = 8'h00;
`else
    localparam logic [DW-1:0] STALE = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst, sensor_state, pix_valid, ap_ready, ap_done, preload;
    logic [DW-1:0] pix_din;
    logic rden, wren, ap_start, init, out_valid, ovf;
    logic [ADDR_W-1:0] rdaddr, wraddr;
    logic [NB*DW-1:0] rddata, wrdata;
    logic [CW-1:0] win_col;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    morph_window_sched dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .sensor_state  (sensor_state),
        .pix_valid     (pix_valid),
        .pix_din       (pix_din),
        .rowbuf_rden   (rden),
        .rowbuf_rdaddr (rdaddr),
        .rowbuf_rddata (rddata),
        .rowbuf_wren   (wren),
        .rowbuf_wraddr (wraddr),
        .rowbuf_wrdata (wrdata),
        .win_col       (win_col),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .init          (init),
        .out_valid     (out_valid),
        .ovf           (ovf)
    );

    // Row-buffer BRAM model: NB buffers, 1-cycle read latency, optional 0xFF fill.
    logic [DW-1:0] mem [NB][1<<ADDR_W];
    always @(posedge clk) begin
        if (preload) begin
            for (int j = 0; j < int'(NB); j++)
                for (int a = 0; a < (1 << ADDR_W); a++)
                    mem[j][a] <= 8'hFF;
        end else if (wren) begin
            for (int j = 0; j < int'(NB); j++)
                mem[j][wraddr] <= wrdata[j*DW +: DW];
        end
        if (rden) begin
            for (int j = 0; j < int'(NB); j++)
                rddata[j*DW +: DW] <= mem[j][rdaddr];
        end
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] mkcol(input logic [DW-1:0] p0, input logic [DW-1:0] hi);
        logic [CW-1:0] r;
        r = '0;
        r[0 +: DW] = p0;
        for (int k = 1; k < int'(NROWS); k++) r[k*DW +: DW] = hi;
        return r;
    endfunction

    typedef struct {
        logic              ss, pv;
        logic [DW-1:0]     din;
        logic              rdy, done;
        logic              e_rden;
        logic [ADDR_W-1:0] e_addr;
        logic              e_wren;
        logic [DW-1:0]     e_wr0;
        logic              e_start, e_init;
        logic [DW-1:0]     e_win0;
        logic              e_ov, e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic ss, input logic pv, input logic [7:0] din, input logic rdy,
                     input logic done, input logic e_rden, input int e_addr, input logic e_wren,
                     input logic [7:0] e_wr0, input logic e_start, input logic e_init,
                     input logic [7:0] e_win0, input logic e_ov, input logic e_ovf);
        vec_t t;
        t.ss = ss; t.pv = pv; t.din = din; t.rdy = rdy; t.done = done;
        t.e_rden = e_rden; t.e_addr = ADDR_W'(e_addr); t.e_wren = e_wren; t.e_wr0 = e_wr0;
        t.e_start = e_start; t.e_init = e_init; t.e_win0 = e_win0; t.e_ov = e_ov; t.e_ovf = e_ovf;
        tbl.push_back(t);
    endtask

    logic [DW-1:0] img [3][IMG_W];
    logic [CW-1:0] expq[$];
    logic          expi[$];

    initial begin
        int x, y, npix, budget;
        logic [CW-1:0] e, got;
        logic gi;

        rst = 1'b1; preload = 1'b1; sensor_state = 1'b0; pix_valid = 1'b0;
        pix_din = '0; ap_ready = 1'b0; ap_done = 1'b0;

        // Directed cycle table: frame start, single pixel latency, ap_done, overflow, drain.
        v(0,0,8'h00,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,0);
        v(1,0,8'h00,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,0);
        v(1,1,8'h5A,0,0, 1,0,0,8'h00, 0,0,8'h00, 0,0);
        v(1,0,8'h00,0,0, 0,0,1,8'h5A, 0,0,8'h00, 0,0);
        v(1,0,8'h00,0,0, 0,0,0,8'h00, 1,1,8'h5A, 0,0);
        v(1,0,8'h00,1,0, 0,0,0,8'h00, 1,1,8'h5A, 0,0);
        v(1,0,8'h00,0,1, 0,0,0,8'h00, 0,0,8'h00, 0,0);
        v(1,0,8'h00,0,0, 0,0,0,8'h00, 0,0,8'h00, 1,0);
        v(1,1,8'h11,0,0, 1,1,0,8'h00, 0,0,8'h00, 0,0);
        v(1,1,8'h22,0,0, 1,2,1,8'h11, 0,0,8'h00, 0,0);
        v(1,1,8'h33,0,0, 1,3,1,8'h22, 1,0,8'h11, 0,0);
        v(1,0,8'h00,0,0, 0,0,1,8'h33, 1,0,8'h11, 0,1);
        v(1,0,8'h00,1,0, 0,0,0,8'h00, 1,0,8'h11, 0,1);
        v(1,1,8'h44,0,0, 1,4,0,8'h00, 0,0,8'h00, 0,1);
        v(0,1,8'h55,0,0, 1,5,1,8'h44, 0,0,8'h00, 0,1);
        v(0,1,8'h66,0,0, 0,0,1,8'h55, 1,0,8'h44, 0,1);
        v(0,0,8'h00,0,0, 0,0,0,8'h00, 1,0,8'h44, 0,1);
        v(0,0,8'h00,1,0, 0,0,0,8'h00, 1,0,8'h44, 0,1);
        v(0,1,8'h77,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,1);
        v(0,1,8'h77,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,1);
        v(1,0,8'h00,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,1);
        v(1,0,8'h00,0,0, 0,0,0,8'h00, 0,0,8'h00, 0,0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ap_start", CW'(ap_start), '0);
        chk("reset ovf", CW'(ovf), '0);
        chk("reset win_col", win_col, '0);
        chk("reset init/out_valid/wren", CW'({init, out_valid, wren}), '0);
        @(posedge clk); #1;
        rst = 1'b0; preload = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            sensor_state = tbl[i].ss; pix_valid = tbl[i].pv; pix_din = tbl[i].din;
            ap_ready = tbl[i].rdy; ap_done = tbl[i].done;
            @(negedge clk);
            chk($sformatf("t%0d rden", i), CW'(rden), CW'(tbl[i].e_rden));
            if (tbl[i].e_rden) chk($sformatf("t%0d rdaddr", i), CW'(rdaddr), CW'(tbl[i].e_addr));
            chk($sformatf("t%0d wren", i), CW'(wren), CW'(tbl[i].e_wren));
            if (tbl[i].e_wren) begin
                chk($sformatf("t%0d wrdata0", i), CW'(wrdata[0 +: DW]), CW'(tbl[i].e_wr0));
                chk($sformatf("t%0d wrdata1", i), CW'(wrdata[DW +: DW]), CW'(STALE));
            end
            chk($sformatf("t%0d ap_start", i), CW'(ap_start), CW'(tbl[i].e_start));
            if (tbl[i].e_start) begin
                chk($sformatf("t%0d init", i), CW'(init), CW'(tbl[i].e_init));
                chk($sformatf("t%0d win_col", i), win_col, mkcol(tbl[i].e_win0, STALE));
            end
            chk($sformatf("t%0d out_valid", i), CW'(out_valid), CW'(tbl[i].e_ov));
            chk($sformatf("t%0d ovf", i), CW'(ovf), CW'(tbl[i].e_ovf));
            @(posedge clk); #1;
        end

        // Fresh frame with clean buffers for the random run.
        pix_valid = 1'b0; ap_done = 1'b0; ap_ready = 1'b1; preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;

        x = 0; y = 0; npix = 0;
        while (npix < 3 * int'(IMG_W)) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_din = 8'($urandom);
            if (pix_valid) begin
                img[y][x] = pix_din;
                for (int k = 0; k < int'(NROWS); k++)
                    e[k*DW +: DW] = (k <= y) ? img[y-k][x] : STALE;
                expq.push_back(e);
                expi.push_back(x == 0);
            end
            @(negedge clk);
            chk("rand rden", CW'(rden), CW'(pix_valid));
            if (pix_valid) chk("rand rdaddr", CW'(rdaddr), CW'(x));
            if (ap_start && ap_ready) begin
                if (expq.size() == 0) begin
                    chk("rand unexpected ap_start", CW'(ap_start), '0);
                end else begin
                    got = expq.pop_front(); gi = expi.pop_front();
                    chk("rand win_col", win_col, got);
                    chk("rand init", CW'(init), CW'(gi));
                end
            end
            @(posedge clk); #1;
            if (pix_valid) begin
                npix++;
                x++;
                if (x == int'(IMG_W)) begin x = 0; y++; end
            end
        end
        pix_valid = 1'b0;
        budget = 0;
        while (expq.size() != 0 && budget < 10) begin
            @(negedge clk);
            if (ap_start && ap_ready) begin
                got = expq.pop_front(); gi = expi.pop_front();
                chk("drain win_col", win_col, got);
                chk("drain init", CW'(init), CW'(gi));
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("rand columns outstanding", CW'(expq.size()), '0);
        chk("rand ovf", CW'(ovf), '0);

        // Reset while a column is held and ovf is set.
        ap_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_din = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset ap_start", CW'(ap_start), CW'(1'b1));
        chk("pre-reset ovf", CW'(ovf), CW'(1'b1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pix_valid = 1'b1;
        @(negedge clk);
        chk("post-reset ap_start", CW'(ap_start), '0);
        chk("post-reset ovf", CW'(ovf), '0);
        chk("post-reset idle rden", CW'(rden), '0);
        chk("post-reset win_col", win_col, '0);
        @(posedge clk); #1;
        pix_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
